// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS load/store unit: opcodes, FSM state encoding,
// lane-select constants and opcode classification helpers.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // addr[HALF_SEL_BIT] picks the upper half-word; byte lane is addr[1:0]
    localparam int HALF_SEL_BIT = 1;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_sub_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH};
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return is_load(op) || is_sub_store(op) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// Combinational lane logic: byte/half extraction with sign/zero extension for loads
// and read-modify-write merge of sub-word store data into the fetched word.
import mips_mem_pkg::*;

module mem_lane_mux (
    input  logic [5:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        byte_v     = word_in[{lane, 3'b000} +: 8];
        half_v     = lane[HALF_SEL_BIT] ? word_in[31:16] : word_in[15:0];
        load_data  = word_in;
        store_word = word_in;
        case (op)
            OP_LB:  load_data = {{24{byte_v[7]}}, byte_v};
            OP_LBU: load_data = {24'h0, byte_v};
            OP_LH:  load_data = {{16{half_v[15]}}, half_v};
            OP_LHU: load_data = {16'h0, half_v};
            OP_SB:  store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            OP_SH: begin
                if (lane[HALF_SEL_BIT]) store_word[31:16] = wdata[15:0];
                else                    store_word[15:0]  = wdata[15:0];
            end
            OP_SW:  store_word = wdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle MIPS load/store controller issuing aligned word accesses to data memory.
// Optional MISALIGN_TRAP_EN: misaligned lh/lhu/sh/lw/sw complete with err instead of accessing memory.
import mips_mem_pkg::*;

module mem_access_unit #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RDATA_RST = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [5:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t      state, next_state;
    logic [5:0]  op_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic        trap;
    logic [31:0] load_data;
    logic [31:0] store_word;

`ifdef MISALIGN_TRAP_EN
    assign trap = !is_legal(op)
                || ((op inside {OP_LH, OP_LHU, OP_SH}) && addr[0])
                || ((op inside {OP_LW, OP_SW}) && (addr[1:0] != 2'b00));
`else
    assign trap = !is_legal(op);
`endif

    mem_lane_mux u_lane_mux (
        .op        (op_q),
        .lane      (lane_q),
        .word_in   (mem_rdata),
        .wdata     (wdata_q),
        .load_data (load_data),
        .store_word(store_word)
    );

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (trap)                            next_state = S_DONE;
                    else if (is_load(op) || is_sub_store(op)) next_state = S_RD;
                    else                                 next_state = S_WR;
                end
            end
            S_RD:    next_state = is_load(op_q) ? S_DONE : S_WR;
            S_WR:    next_state = S_DONE;
            default: next_state = S_IDLE;
        endcase
    end

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign err    = done && err_q;
    assign mem_we = (state == S_WR);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            lane_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= RDATA_RST;
        end else begin
            state <= next_state;
            if (state == S_IDLE && req) begin
                op_q    <= op;
                lane_q  <= addr[1:0];
                wdata_q <= wdata;
                err_q   <= trap;
                if (!trap) begin
                    mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                    mem_wdata <= wdata;
                end
            end
            // RD either finishes a load or captures the merged word for the following WR
            if (state == S_RD) begin
                if (is_load(op_q)) rdata     <= load_data;
                else               mem_wdata <= store_word;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random loads/stores
// against a word-array reference model with arithmetic lane handling.
module tb_mem_access_unit;

    localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011, LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy, done, err, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] ref_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_unit dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .op       (op),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one access and compares timing, err, write count, rdata and memory against the model.
    task automatic run_op(input logic [5:0] o, input logic [11:0] a, input logic [31:0] wd,
                          input bit hold);
        int          idx;
        logic [31:0] w, byte_v, half_v;
        int          sh;
        bit          legal, trap;
        int          exp_cycle, exp_writes, exp_we_cycle;
        int          k, done_k, writes, we_k;
        bit          got_done, err_v, busy_bad;

        idx    = int'(a[11:2]);
        w      = ref_mem[idx];
        byte_v = (w >> (8 * a[1:0])) & 32'hFF;
        half_v = (w >> (16 * a[1])) & 32'hFFFF;
        legal  = o inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
        trap   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = ((o == LH || o == LHU || o == SH) && a[0]) || ((o == LW || o == SW) && a[1:0] != 2'b00);
`endif
        exp_writes   = 0;
        exp_we_cycle = 0;
        if (!legal || trap) begin
            exp_cycle = 1;
        end else begin
            case (o)
                LB:  begin exp_cycle = 2; ref_rdata = (byte_v >= 128) ? (byte_v | 32'hFFFF_FF00) : byte_v; end
                LBU: begin exp_cycle = 2; ref_rdata = byte_v; end
                LH:  begin exp_cycle = 2; ref_rdata = (half_v >= 32768) ? (half_v | 32'hFFFF_0000) : half_v; end
                LHU: begin exp_cycle = 2; ref_rdata = half_v; end
                LW:  begin exp_cycle = 2; ref_rdata = w; end
                SB: begin
                    exp_cycle = 3; exp_writes = 1; exp_we_cycle = 2;
                    sh = 8 * a[1:0];
                    ref_mem[idx] = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
                end
                SH: begin
                    exp_cycle = 3; exp_writes = 1; exp_we_cycle = 2;
                    sh = 16 * a[1];
                    ref_mem[idx] = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
                end
                default: begin
                    exp_cycle = 2; exp_writes = 1; exp_we_cycle = 1;
                    ref_mem[idx] = wd;
                end
            endcase
        end

        @(negedge clk);
        req = 1'b1; op = o; addr = {20'h0, a}; wdata = wd;
        k = 0; done_k = 0; writes = 0; we_k = 0; got_done = 0; err_v = 0; busy_bad = 0;
        while (!got_done && k < 8) begin
            @(negedge clk);
            k++;
            if (!hold) req = 1'b0;
            if (!busy) busy_bad = 1'b1;
            if (mem_we) begin writes++; we_k = k; end
            if (done) begin
                got_done = 1'b1; done_k = k; err_v = err;
                req = 1'b0;
            end else if (err) begin
                busy_bad = 1'b1;
            end
        end
        check($sformatf("timeout op=%b a=%h", o, a), 32'(got_done), 32'd1);
        check($sformatf("done_cycle op=%b a=%h", o, a), done_k, exp_cycle);
        check($sformatf("err op=%b a=%h", o, a), 32'(err_v), 32'(!legal || trap));
        check($sformatf("busy/err_pulse op=%b a=%h", o, a), 32'(busy_bad), 32'd0);
        check($sformatf("writes op=%b a=%h", o, a), writes, exp_writes);
        if (exp_writes != 0) check($sformatf("we_cycle op=%b a=%h", o, a), we_k, exp_we_cycle);
        check($sformatf("rdata op=%b a=%h", o, a), rdata, ref_rdata);
        check($sformatf("mem op=%b a=%h", o, a), mem[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [5:0] ops [10];
        int         bad;

        ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'b000000, 6'b101111};
        rst = 1'b1; req = 1'b0; op = '0; addr = '0; wdata = '0;
        ref_rdata = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = (i < 64) ? $urandom : 32'h0;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h8070_F0A5; ref_mem[4] = 32'h8070_F0A5;
        mem[8] = 32'h1122_3344; ref_mem[8] = 32'h1122_3344;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        rst = 1'b0;

        run_op(LB, 12'h010, 32'h0, 0);  check("lb_0x10", rdata, 32'hFFFF_FFA5);
        run_op(LBU, 12'h011, 32'h0, 0); check("lbu_0x11", rdata, 32'h0000_00F0);
        run_op(LH, 12'h012, 32'h0, 0);  check("lh_0x12", rdata, 32'hFFFF_8070);
        run_op(LHU, 12'h012, 32'h0, 0); check("lhu_0x12", rdata, 32'h0000_8070);
        run_op(LW, 12'h010, 32'h0, 0);  check("lw_0x10", rdata, 32'h8070_F0A5);
        run_op(SB, 12'h022, 32'h5555_55AB, 0); check("sb_0x22", mem[8], 32'h11AB_3344);
        run_op(SH, 12'h020, 32'h0000_BEEF, 0); check("sh_0x20", mem[8], 32'h11AB_BEEF);
        run_op(SW, 12'h030, 32'hDEAD_BEEF, 1); check("sw_0x30", mem[12], 32'hDEAD_BEEF);
        @(negedge clk);
        check("hold_req_idle", 32'(busy), 32'd0);
        check("hold_req_no_we", 32'(mem_we), 32'd0);
        run_op(6'b000000, 12'h030, 32'h1234_5678, 0);
        run_op(LW, 12'h031, 32'h0, 0);
`ifndef MISALIGN_TRAP_EN
        check("lw_0x31_noTrap", rdata, 32'hDEAD_BEEF);
`endif

        // Reset while an sb sits in RD: must abandon the write entirely
        @(negedge clk);
        req = 1'b1; op = SB; addr = 32'h20; wdata = 32'h77;
        @(negedge clk);
        req = 1'b0;
        check("rd_busy_before_rst", 32'(busy), 32'd1);
        bad = mem_we ? 1 : 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_rdata = 32'h0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_mem_addr", mem_addr, 32'h0);
        check("rst_mid_rdata", rdata, 32'h0);
        repeat (2) begin
            @(negedge clk);
            if (mem_we || busy) bad++;
        end
        check("rst_mid_no_write", bad, 0);
        check("rst_mid_mem", mem[8], ref_mem[8]);

        for (int n = 0; n < 80; n++) begin
            run_op(ops[$urandom_range(0, (n % 10 == 9) ? 9 : 7)], 12'($urandom_range(0, 255)),
                   $urandom, 0);
        end

        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("final_mem_words_differing", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
